// File: rtl/control_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit for a small register-file CPU. It steps through a
// fetch (T0..T2) and an opcode-specific execute sequence (T3..T7), emitting
// one set of datapath strobes per step. Strobes are a function of the current
// step and the opcode in ir[31:27]; mem_ready only qualifies the memory
// wait steps (T1 fetch read, ld read in T6, st write in T7).
//
// Ports
//   clock      system clock, rising-edge active
//   clear_n    asynchronous active-low reset (returns to IDLE, outputs 0)
//   run        start request, only looked at in IDLE
//   ir         instruction register contents, opcode = ir[31:27]
//   mem_ready  memory read/write completes this cycle
//   Gra/Grb/Grc, Rin/Rout/BAout   register-file select and strobes
//   PCout..Write                  datapath strobes
//   alu_op     ADD=0000 SUB=0001 AND=0010 OR=0011
//   done/illegal/halted           instruction status
//   state      current step encoding for debug
// -----------------------------------------------------------------------------
module control_sequencer (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  alu_op,
  output logic        done,
  output logic        illegal,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4   = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t      state_r;
  state_t      next_state_s;
  logic [4:0]  opcode_s;
  logic        is_alu_s;
  logic        is_addi_s;
  logic        is_ld_s;
  logic        is_st_s;
  logic        is_nop_s;
  logic        is_halt_s;
  // Operand fields are consumed by the datapath select/encode logic, not here.
  logic        unused_ir_s;

  // ALU operation for the register-register ALU opcodes.
  function automatic logic [3:0] alu_sel(input logic [4:0] op);
    case (op)
      OP_SUB:  alu_sel = 4'b0001;
      OP_AND:  alu_sel = 4'b0010;
      OP_OR:   alu_sel = 4'b0011;
      default: alu_sel = 4'b0000;
    endcase
  endfunction

  assign opcode_s    = ir[31:27];
  assign unused_ir_s = ^ir[26:0];
  assign is_alu_s    = (opcode_s == OP_ADD) || (opcode_s == OP_SUB) ||
                       (opcode_s == OP_AND) || (opcode_s == OP_OR);
  assign is_addi_s   = (opcode_s == OP_ADDI);
  assign is_ld_s     = (opcode_s == OP_LD);
  assign is_st_s     = (opcode_s == OP_ST);
  assign is_nop_s    = (opcode_s == OP_NOP);
  assign is_halt_s   = (opcode_s == OP_HALT);
  assign state       = state_r;

  // Step register; reset abandons any instruction in flight.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Step sequencing. Opcode only matters from T3 onward.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: if (run) next_state_s = T0; else next_state_s = IDLE;
      T0:   next_state_s = T1;
      T1:   if (mem_ready) next_state_s = T2; else next_state_s = T1;
      T2:   next_state_s = T3;
      T3: begin
        if (is_halt_s) begin
          next_state_s = HALT;
        end else if (is_alu_s || is_addi_s || is_ld_s || is_st_s) begin
          next_state_s = T4;
        end else begin
          next_state_s = T0;  // nop and illegal finish here
        end
      end
      T4:   next_state_s = T5;
      T5:   if (is_ld_s || is_st_s) next_state_s = T6; else next_state_s = T0;
      T6: begin
        if (is_ld_s) begin
          if (mem_ready) next_state_s = T7; else next_state_s = T6;
        end else if (is_st_s) begin
          next_state_s = T7;
        end else begin
          next_state_s = T0;
        end
      end
      T7:   if (is_st_s && !mem_ready) next_state_s = T7; else next_state_s = T0;
      HALT: next_state_s = HALT;
      default: next_state_s = IDLE;
    endcase
  end

  // Per-step strobes; anything not named for a step stays low.
  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    Cout = 1'b0; Read = 1'b0; Write = 1'b0; alu_op = 4'b0000;
    done = 1'b0; illegal = 1'b0; halted = 1'b0;
    case (state_r)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        // PC is only updated once the fetch read has actually completed.
        if (mem_ready) begin
          PCin = 1'b1; Zlowout = 1'b1;
        end else begin
          PCin = 1'b0; Zlowout = 1'b0;
        end
      end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (is_alu_s || is_addi_s) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ld_s || is_st_s) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_nop_s || is_halt_s) begin
          done = 1'b1;
        end else begin
          illegal = 1'b1; done = 1'b1;
        end
      end
      T4: begin
        if (is_alu_s) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_sel(opcode_s);
        end else if (is_addi_s || is_ld_s || is_st_s) begin
          Cout = 1'b1; Zin = 1'b1;
        end else begin
          Zin = 1'b0;
        end
      end
      T5: begin
        if (is_alu_s || is_addi_s) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
        end else if (is_ld_s || is_st_s) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else begin
          Zlowout = 1'b0;
        end
      end
      T6: begin
        if (is_ld_s) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st_s) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else begin
          MDRin = 1'b0;
        end
      end
      T7: begin
        if (is_ld_s) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
        end else if (is_st_s) begin
          Write = 1'b1; done = mem_ready;
        end else begin
          done = 1'b0;
        end
      end
      HALT: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

endmodule
